// File: rtl/frame_buffer_dbl.sv
// Double-buffered pixel store: drawing logic writes the back bank, the VGA side reads the front bank.
// Optional back-bank fill engine compiled in with `define FRAMEBUF_CLEAR_EN.
module frame_buffer_dbl #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int COLOR_BITS = 4,
    parameter int BG_COLOR   = 0
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic [9:0]            Wr_X,
    input  logic [9:0]            Wr_Y,
    input  logic                  Wr_En,
    input  logic [COLOR_BITS-1:0] Wr_Color,
    input  logic [9:0]            Rd_X,
    input  logic [9:0]            Rd_Y,
    input  logic                  Rd_En,
    output logic [COLOR_BITS-1:0] Rd_Color,
    output logic                  Rd_Valid,
    input  logic                  Frame_End,
    input  logic                  Swap_Req,
    output logic                  Swap_Ack,
    output logic                  Front_Sel,
    input  logic                  Clear_Req,
    input  logic [COLOR_BITS-1:0] Clear_Color,
    output logic                  Busy
);

    localparam int PIXELS = WIDTH * HEIGHT;
    localparam int AW     = $clog2(PIXELS);

`ifdef FRAMEBUF_CLEAR_EN
    typedef enum logic [1:0] {IDLE, SWAP_PEND, CLEARING} state_t;
`else
    typedef enum logic {IDLE, SWAP_PEND} state_t;
`endif

    state_t state;

    // Both banks share one array; the top address bit selects the bank.
    logic [COLOR_BITS-1:0] mem [0:2*PIXELS-1];

    logic [AW-1:0]         wr_lin;
    logic [AW-1:0]         rd_lin;
    logic                  wr_in;
    logic                  rd_in;
    logic                  wr_ok;
    logic                  mem_we;
    logic [AW:0]           mem_waddr;
    logic [COLOR_BITS-1:0] mem_wdata;

    assign wr_in  = (32'(Wr_X) < WIDTH) && (32'(Wr_Y) < HEIGHT);
    assign rd_in  = (32'(Rd_X) < WIDTH) && (32'(Rd_Y) < HEIGHT);
    assign wr_lin = AW'(32'(Wr_Y) * 32'(WIDTH) + 32'(Wr_X));
    assign rd_lin = AW'(32'(Rd_Y) * 32'(WIDTH) + 32'(Rd_X));
    assign wr_ok  = Wr_En && wr_in && !Busy;

`ifdef FRAMEBUF_CLEAR_EN
    logic [AW-1:0]         clr_cnt;
    logic [COLOR_BITS-1:0] clr_color;
    logic                  swap_pending;

    // The fill engine owns the write port while Busy; drawing writes are dropped.
    assign mem_we    = Busy || wr_ok;
    assign mem_waddr = Busy ? {~Front_Sel, clr_cnt} : {~Front_Sel, wr_lin};
    assign mem_wdata = Busy ? clr_color : Wr_Color;
`else
    logic unused_clear;

    assign unused_clear = ^{Clear_Req, Clear_Color};
    assign Busy         = 1'b0;
    assign mem_we       = wr_ok;
    assign mem_waddr    = {~Front_Sel, wr_lin};
    assign mem_wdata    = Wr_Color;
`endif

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    // Reads always target the front bank as sampled on the Rd_En edge.
    always_ff @(posedge clk) begin
        if (Reset) begin
            Rd_Valid <= 1'b0;
            Rd_Color <= '0;
        end else begin
            Rd_Valid <= Rd_En;
            if (!Rd_En)
                Rd_Color <= '0;
            else if (!rd_in)
                Rd_Color <= COLOR_BITS'(BG_COLOR);
            else
                Rd_Color <= mem[{Front_Sel, rd_lin}];
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= IDLE;
            Front_Sel <= 1'b0;
            Swap_Ack  <= 1'b0;
`ifdef FRAMEBUF_CLEAR_EN
            Busy         <= 1'b0;
            clr_cnt      <= '0;
            clr_color    <= '0;
            swap_pending <= 1'b0;
`endif
        end else begin
            Swap_Ack <= 1'b0;
            case (state)
                IDLE: begin
`ifdef FRAMEBUF_CLEAR_EN
                    if (Clear_Req) begin
                        state        <= CLEARING;
                        Busy         <= 1'b1;
                        clr_cnt      <= '0;
                        clr_color    <= Clear_Color;
                        swap_pending <= Swap_Req;
                    end else
`endif
                    if (Swap_Req) begin
                        if (Frame_End) begin
                            Front_Sel <= ~Front_Sel;
                            Swap_Ack  <= 1'b1;
                        end else begin
                            state <= SWAP_PEND;
                        end
                    end
                end
                SWAP_PEND: begin
                    if (Frame_End) begin
                        Front_Sel <= ~Front_Sel;
                        Swap_Ack  <= 1'b1;
                        state     <= IDLE;
                    end
                end
`ifdef FRAMEBUF_CLEAR_EN
                CLEARING: begin
                    if (Swap_Req)
                        swap_pending <= 1'b1;
                    if (clr_cnt == AW'(PIXELS - 1)) begin
                        // A swap requested during the fill waits for the next Frame_End.
                        clr_cnt      <= '0;
                        Busy         <= 1'b0;
                        swap_pending <= 1'b0;
                        state        <= (swap_pending || Swap_Req) ? SWAP_PEND : IDLE;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/frame_buffer_dbl.md
# frame_buffer_dbl

Parametrised, double-buffered pixel store between the game/sprite drawing logic and the VGA controller. The drawing side writes into the back bank while the VGA side reads the front bank. Banks swap only on a frame boundary, so a frame is never torn. An optional hardware clear engine fills the back bank with a single colour.

## Interface
Parameters:
- WIDTH, 160, pixels per line
- HEIGHT, 120, lines per frame
- COLOR_BITS, 4, bits per pixel
- BG_COLOR, 0, value returned for out-of-range reads

Ports:
- clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- Wr_X, Wr_Y  in  10  back-bank write coordinates
- Wr_En  in  1  write strobe
- Wr_Color  in  COLOR_BITS  write data
- Rd_X, Rd_Y  in  10  front-bank read coordinates
- Rd_En  in  1  read strobe
- Rd_Color  out  COLOR_BITS  read data, registered
- Rd_Valid  out  1  Rd_Color valid this cycle
- Frame_End  in  1  one-cycle pulse from the VGA controller at vblank start
- Swap_Req  in  1  request a bank swap at the next Frame_End
- Swap_Ack  out  1  one-cycle pulse, high the cycle after the swap takes effect
- Front_Sel  out  1  bank currently displayed (0 = bank A)
- Clear_Req  in  1  start a back-bank fill
- Clear_Color  in  COLOR_BITS  fill value, latched when the clear starts
- Busy  out  1  high while a clear is running

## Operation
- **Storage.** Two banks of WIDTH*HEIGHT words, each COLOR_BITS wide. Linear index = Y*WIDTH + X. The back bank is !Front_Sel.
- **Writes.** A write goes to the back bank when Wr_En=1, Wr_X<WIDTH, Wr_Y<HEIGHT and the block is not clearing. Otherwise the write is dropped silently.
- **Reads.** Rd_En=1 registers a read from the front bank, giving Rd_Color and Rd_Valid=1 on the next cycle.
  - Out-of-range coordinates return BG_COLOR with Rd_Valid=1.
  - When Rd_Valid=0, Rd_Color=0.
- **FSM states:** IDLE, SWAP_PEND, CLEARING.
  - IDLE + Clear_Req goes to CLEARING. If Swap_Req is also high, the swap_pending flag is set.
  - IDLE + Swap_Req (no Clear_Req) goes to SWAP_PEND. If Frame_End is high in the same cycle, the swap happens on this edge and the state returns to IDLE.
  - In SWAP_PEND, Frame_End toggles Front_Sel, pulses Swap_Ack and returns to IDLE. Swap_Req while in SWAP_PEND is ignored.
  - In CLEARING, a pixel counter runs 0 to WIDTH*HEIGHT-1. Each cycle it writes the latched Clear_Color to the back bank. On the last pixel the state goes to SWAP_PEND if swap_pending is set, else to IDLE. Swap_Req during CLEARING sets swap_pending. Clear_Req during CLEARING is ignored.
- A swap never happens while CLEARING.
- Reads continue undisturbed in every state.

## Timing
- **Reset values:** Rd_Color=0, Rd_Valid=0, Swap_Ack=0, Front_Sel=0, Busy=0, state=IDLE, swap_pending=0, pixel counter=0. Memory contents are undefined after reset.
- **Reset mid-clear** abandons the fill. Pixels already written keep their values.
- **Read latency:** 1 cycle. A read sees Front_Sel as sampled on the Rd_En edge.
- **Swap latency:** Front_Sel changes on the edge that samples Frame_End. Swap_Ack is high for the following cycle.
- **Clear duration:** Busy rises the cycle after Clear_Req and stays high for exactly WIDTH*HEIGHT cycles.
- **Counter wrap:** the counter is clog2(WIDTH*HEIGHT) bits and resets to 0 at end of clear; it never wraps mid-fill.
- **Write visibility:** a write on edge N is readable only after a subsequent swap.

## Configuration
- FRAMEBUF_CLEAR_EN defined: the clear engine, the CLEARING state and swap_pending are compiled in, and behave as described above.
- FRAMEBUF_CLEAR_EN undefined:
  - Clear_Req and Clear_Color are present but ignored.
  - Busy is tied to 0.
  - The FSM is IDLE/SWAP_PEND only.

## Test plan
- **Reset, then read (0,0):** Reset for 2 cycles, then Rd_En at (0,0). Required: Front_Sel=0 and Rd_Valid=1 one cycle later; Rd_Color must not be X if the bench preloads memory.
- **Write, swap, read:** Write 4'hA at (5,7). Swap_Req, then Frame_End 10 cycles later. Required: Front_Sel=1 on the Frame_End edge and Swap_Ack a 1-cycle pulse. A subsequent read at (5,7) returns 4'hA one cycle after Rd_En.
- **Out-of-range access:** Write 4'h3 at (160,0), then swap. Required: a read at (160,0) returns BG_COLOR and a read at (0,1) is unchanged.
- **Swap and Frame_End in the same cycle:** Both asserted together from IDLE. Required: Front_Sel toggles on that edge and Swap_Ack is high next cycle.
- **Clear with queued swap (FRAMEBUF_CLEAR_EN):** Clear_Req with Clear_Color=4'h5, plus Swap_Req during the fill, plus Frame_End pulses throughout. Required:
  - Busy is high for exactly 19200 cycles.
  - No swap occurs while Busy=1.
  - The swap happens at the first Frame_End after Busy falls.
  - All 19200 front pixels then read 4'h5.
  - Wr_En during the clear has no effect.
- **Reset mid-clear:** Reset at pixel 100 of a clear. Required: Busy=0 next cycle, state IDLE, and a new Clear_Req restarts from pixel 0.
